// File: rtl/ps2_key_fifo_if.sv
// ps2_key_fifo_if: CPU-side MMIO bus of the PS/2 key FIFO.
//   a   : register select (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   d   : write data
//   we  : write strobe, one cycle
//   rd  : read strobe, one cycle (pops the FIFO when a==0)
//   spo : read data, combinational from a and the FIFO head
//   irq : level interrupt, irq_en & !empty
interface ps2_key_fifo_if;
  logic [1:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        irq;

  modport master (output a, d, we, rd, input spo, irq);
  modport slave  (input a, d, we, rd, output spo, irq);
endinterface

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: turns ps2_driver keycode history into make/break/extended
// events with shift/ctrl/caps state, optionally translates set-2 scan codes
// to ASCII, and buffers the events in a FIFO read over the MMIO bus.
// Optional feature macro: PS2_ASCII_EN (ASCII table; ascii field is 00 without it).
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous active-low reset
//   keycode     ps2_driver keycodeout ([7:0] last byte, [15:8], [23:16] older)
//   newkeypress ps2_driver strobe, asynchronous to clk
//   bus         MMIO slave (a, d, we, rd, spo, irq)
module ps2_key_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   keycode,
  input  logic          newkeypress,
  ps2_key_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic               r_sync1, r_sync2, r_sync3;
  logic               r_evt;
  logic [23:0]        r_kc;
  logic               r_shift, r_ctrl, r_caps;
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_ovf;
  logic               r_irq_en;
  logic [31:0]        r_mem [DEPTH];

  logic        w_detect;
  logic [7:0]  w_sc;
  logic        w_brk, w_ext;
  logic        w_shift_n, w_ctrl_n, w_caps_n;
  logic [7:0]  w_ascii;
  logic [31:0] w_entry;
  logic        w_empty, w_full;
  logic        w_ctrl_wr, w_flush, w_pop, w_push, w_push_ok, w_drop;
  logic [31:0] w_status;
  logic [31:0] w_spo;
  logic        w_unused;

  // Rising edge of the synchronised strobe marks a new keycode.
  assign w_detect = r_sync2 & ~r_sync3;

  // Decode of the captured keycode history.
  assign w_sc  = r_kc[7:0];
  assign w_brk = (r_kc[15:8] == 8'hF0);
  assign w_ext = (r_kc[15:8] == 8'hE0) | (w_brk & (r_kc[23:16] == 8'hE0));

  // Modifier state after this event; the entry carries the updated flags.
  always_comb begin
    w_shift_n = r_shift;
    w_ctrl_n  = r_ctrl;
    w_caps_n  = r_caps;
    if (!w_ext && (w_sc == 8'h12 || w_sc == 8'h59)) w_shift_n = ~w_brk;
    if (w_sc == 8'h14) w_ctrl_n = ~w_brk;
    if (w_sc == 8'h58 && !w_brk) w_caps_n = ~r_caps;
  end

`ifdef PS2_ASCII_EN
  logic [7:0] w_lo, w_hi;
  logic       w_letter, w_up;

  // Set-2 table: w_lo unshifted, w_hi shifted (letters derive their upper case).
  always_comb begin
    w_lo = 8'h00;
    w_hi = 8'h00;
    case (w_sc)
      8'h1C: w_lo = "a";  8'h32: w_lo = "b";  8'h21: w_lo = "c";
      8'h23: w_lo = "d";  8'h24: w_lo = "e";  8'h2B: w_lo = "f";
      8'h34: w_lo = "g";  8'h33: w_lo = "h";  8'h43: w_lo = "i";
      8'h3B: w_lo = "j";  8'h42: w_lo = "k";  8'h4B: w_lo = "l";
      8'h3A: w_lo = "m";  8'h31: w_lo = "n";  8'h44: w_lo = "o";
      8'h4D: w_lo = "p";  8'h15: w_lo = "q";  8'h2D: w_lo = "r";
      8'h1B: w_lo = "s";  8'h2C: w_lo = "t";  8'h3C: w_lo = "u";
      8'h2A: w_lo = "v";  8'h1D: w_lo = "w";  8'h22: w_lo = "x";
      8'h35: w_lo = "y";  8'h1A: w_lo = "z";
      8'h45: begin w_lo = "0"; w_hi = ")"; end
      8'h16: begin w_lo = "1"; w_hi = "!"; end
      8'h1E: begin w_lo = "2"; w_hi = "@"; end
      8'h26: begin w_lo = "3"; w_hi = "#"; end
      8'h25: begin w_lo = "4"; w_hi = "$"; end
      8'h2E: begin w_lo = "5"; w_hi = "%"; end
      8'h36: begin w_lo = "6"; w_hi = "^"; end
      8'h3D: begin w_lo = "7"; w_hi = "&"; end
      8'h3E: begin w_lo = "8"; w_hi = "*"; end
      8'h46: begin w_lo = "9"; w_hi = "("; end
      8'h29: begin w_lo = 8'h20; w_hi = 8'h20; end
      8'h5A: begin w_lo = 8'h0D; w_hi = 8'h0D; end
      8'h66: begin w_lo = 8'h08; w_hi = 8'h08; end
      8'h0D: begin w_lo = 8'h09; w_hi = 8'h09; end
      8'h76: begin w_lo = 8'h1B; w_hi = 8'h1B; end
      8'h0E: begin w_lo = 8'h60; w_hi = 8'h7E; end
      8'h4E: begin w_lo = 8'h2D; w_hi = 8'h5F; end
      8'h55: begin w_lo = 8'h3D; w_hi = 8'h2B; end
      8'h54: begin w_lo = 8'h5B; w_hi = 8'h7B; end
      8'h5B: begin w_lo = 8'h5D; w_hi = 8'h7D; end
      8'h5D: begin w_lo = 8'h5C; w_hi = 8'h7C; end
      8'h4C: begin w_lo = 8'h3B; w_hi = 8'h3A; end
      8'h52: begin w_lo = 8'h27; w_hi = 8'h22; end
      8'h41: begin w_lo = 8'h2C; w_hi = 8'h3C; end
      8'h49: begin w_lo = 8'h2E; w_hi = 8'h3E; end
      8'h4A: begin w_lo = 8'h2F; w_hi = 8'h3F; end
      default: ;
    endcase
  end

  // Only letters have an unshifted code in a..z, so the range identifies them.
  assign w_letter = (w_lo >= 8'h61) && (w_lo <= 8'h7A);
  assign w_up     = w_shift_n ^ w_caps_n;
  assign w_ascii  = w_ext    ? 8'h00 :
                    w_letter ? (w_up ? (w_lo - 8'h20) : w_lo) :
                               (w_shift_n ? w_hi : w_lo);
`else
  assign w_ascii = 8'h00;
`endif

  assign w_entry = {8'h00, w_sc, w_brk, w_ext, w_shift_n, w_ctrl_n, w_caps_n,
                    3'b000, w_ascii};

  // FIFO control; flush discards a coincident push.
  assign w_empty   = (r_count == CW'(0));
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_ctrl_wr = bus.we & (bus.a == 2'd2);
  assign w_flush   = w_ctrl_wr & bus.d[0];
  assign w_pop     = bus.rd & (bus.a == 2'd0) & ~w_empty;
  assign w_push    = r_evt & ~w_flush;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // Register read mux.
  always_comb begin
    w_status       = 32'h0;
    w_status[0]    = ~w_empty;
    w_status[1]    = w_full;
    w_status[2]    = r_ovf;
    w_status[3]    = r_irq_en;
    w_status[15:8] = 8'(r_count);
    w_spo          = 32'h0;
    case (bus.a)
      2'd0:    w_spo = w_empty ? 32'h0 : r_mem[r_rptr];
      2'd1:    w_spo = w_status;
      2'd2:    w_spo = {28'h0, r_irq_en, 3'b000};
      default: w_spo = 32'h0;
    endcase
  end

  assign bus.spo = w_spo;
  assign bus.irq = r_irq_en & ~w_empty;

  // Upper history byte and unused CTRL bits carry no function.
  assign w_unused = ^{keycode[31:24], bus.d[31:4], bus.d[2]};

  // Synchroniser, event capture, modifiers, pointers and control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_evt    <= 1'b0;
      r_kc     <= 24'h0;
      r_shift  <= 1'b0;
      r_ctrl   <= 1'b0;
      r_caps   <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_sync1 <= newkeypress;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_evt   <= w_detect;
      if (w_detect) r_kc <= keycode[23:0];
      if (r_evt) begin
        r_shift <= w_shift_n;
        r_ctrl  <= w_ctrl_n;
        r_caps  <= w_caps_n;
      end
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + FIFO_AW'(1);
        if (w_pop)     r_rptr <= r_rptr + FIFO_AW'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
      // A drop in the same cycle as a clear leaves overflow set.
      if (w_ctrl_wr && bus.d[1]) r_ovf <= 1'b0;
      if (w_drop)                r_ovf <= 1'b1;
      if (w_ctrl_wr)             r_irq_en <= bus.d[3];
    end
  end

  // Storage array, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_entry;
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: directed self-checking bench for ps2_key_fifo.
module tb_ps2_key_fifo;

`ifdef PS2_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] keycode = 32'h0;
  logic        newkeypress = 1'b0;
  int          checks = 0;
  int          errors = 0;

  ps2_key_fifo_if bus_if ();

  ps2_key_fifo #(.FIFO_AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .keycode     (keycode),
    .newkeypress (newkeypress),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] asc(input logic [7:0] c);
    return ASC ? {24'h0, c} : 32'h0;
  endfunction

  task automatic bus_idle();
    bus_if.a  = 2'd0;
    bus_if.d  = 32'h0;
    bus_if.we = 1'b0;
    bus_if.rd = 1'b0;
  endtask

  task automatic do_reset();
    newkeypress = 1'b0;
    bus_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_key(input logic [31:0] kc);
    keycode = kc;
    newkeypress = 1'b1;
    repeat (3) @(negedge clk);
    newkeypress = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [31:0] v);
    bus_if.a = addr;
    #1;
    v = bus_if.spo;
  endtask

  task automatic pop_reg(output logic [31:0] v);
    bus_if.a  = 2'd0;
    bus_if.rd = 1'b1;
    #1;
    v = bus_if.spo;
    @(negedge clk);
    bus_if.rd = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] v);
    bus_if.a  = addr;
    bus_if.d  = v;
    bus_if.we = 1'b1;
    @(negedge clk);
    bus_if.we = 1'b0;
    bus_if.d  = 32'h0;
    bus_if.a  = 2'd0;
  endtask

  // Key event whose push cycle coincides with a bus op (rd pop or CTRL write).
  task automatic key_with_op(input logic [31:0] kc, input bit is_pop, input logic [31:0] ctrl);
    keycode = kc;
    newkeypress = 1'b1;
    repeat (3) @(negedge clk);
    if (is_pop) begin
      bus_if.a = 2'd0; bus_if.rd = 1'b1;
    end else begin
      bus_if.a = 2'd2; bus_if.d = ctrl; bus_if.we = 1'b1;
    end
    @(negedge clk);
    bus_idle();
    newkeypress = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    newkeypress = 1'b0;
    bus_idle();
    rst = 1'b0;
    @(negedge clk);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h0); end
    read_reg(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", v, 32'h0); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus_if.irq); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] v;
    do_reset();
    send_key(32'h0000001C);
    read_reg(2'd0, v);
    checks++; if (v !== (32'h001C0000 | asc(8'h61))) begin errors++; $display("FAIL basic_data: got %h expected %h", v, 32'h001C0000 | asc(8'h61)); end
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000101) begin errors++; $display("FAIL basic_status: got %h expected %h", v, 32'h00000101); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL basic_irq_off: got %b expected 0", bus_if.irq); end
    write_reg(2'd2, 32'h8);
    #1;
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL basic_irq_on: got %b expected 1", bus_if.irq); end
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000109) begin errors++; $display("FAIL basic_status_irqen: got %h expected %h", v, 32'h00000109); end
    pop_reg(v);
    checks++; if (v !== (32'h001C0000 | asc(8'h61))) begin errors++; $display("FAIL basic_pop: got %h expected %h", v, 32'h001C0000 | asc(8'h61)); end
    #1;
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL basic_irq_drained: got %b expected 0", bus_if.irq); end
    pop_reg(v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL pop_empty_data: got %h expected %h", v, 32'h0); end
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000008) begin errors++; $display("FAIL pop_empty_status: got %h expected %h", v, 32'h8); end
    write_reg(2'd3, 32'hFFFFFFFF);
    read_reg(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected %h", v, 32'h0); end
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000008) begin errors++; $display("FAIL reserved_write: got %h expected %h", v, 32'h8); end
  endtask

  task automatic test_modifiers();
    logic [31:0] kcs [12];
    logic [31:0] exps [12];
    logic [31:0] v;
    kcs = '{32'h00000012, 32'h0000121C, 32'h0012F012, 32'h0012F01C,
            32'h00000014, 32'h0014F014, 32'h00000058, 32'h0000581C,
            32'h0058F058, 32'h00000058, 32'h00000012, 32'h00001216};
    exps = '{32'h00122000, 32'h001C2000 | asc(8'h41), 32'h00128000, 32'h001C8000 | asc(8'h61),
             32'h00141000, 32'h00148000, 32'h00580800, 32'h001C0800 | asc(8'h41),
             32'h00588800, 32'h00580000, 32'h00122000, 32'h00162000 | asc(8'h21)};
    do_reset();
    for (int i = 0; i < 12; i++) send_key(kcs[i]);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000C01) begin errors++; $display("FAIL mod_status: got %h expected %h", v, 32'h00000C01); end
    for (int i = 0; i < 12; i++) begin
      pop_reg(v);
      checks++; if (v !== exps[i]) begin errors++; $display("FAIL mod_entry%0d: got %h expected %h", i, v, exps[i]); end
    end
  endtask

  task automatic test_extended();
    logic [31:0] kcs [5];
    logic [31:0] exps [5];
    logic [31:0] v;
    kcs  = '{32'h0000E075, 32'h00E0F075, 32'h0000E012, 32'h0000001C, 32'h0000E014};
    exps = '{32'h00754000, 32'h0075C000, 32'h00124000, 32'h001C0000 | asc(8'h61), 32'h00145000};
    do_reset();
    for (int i = 0; i < 5; i++) send_key(kcs[i]);
    for (int i = 0; i < 5; i++) begin
      pop_reg(v);
      checks++; if (v !== exps[i]) begin errors++; $display("FAIL ext_entry%0d: got %h expected %h", i, v, exps[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 17; i++) send_key({24'h0, 8'(8'h80 + i)});
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00001007) begin errors++; $display("FAIL ovf_status: got %h expected %h", v, 32'h00001007); end
    for (int i = 0; i < 16; i++) begin
      pop_reg(v);
      checks++; if (v !== {8'h00, 8'(8'h80 + i), 16'h0}) begin errors++; $display("FAIL ovf_entry%0d: got %h expected %h", i, v, {8'h00, 8'(8'h80 + i), 16'h0}); end
    end
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000004) begin errors++; $display("FAIL ovf_sticky: got %h expected %h", v, 32'h4); end
    send_key(32'h000000A1);
    send_key(32'h000000A2);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00000205) begin errors++; $display("FAIL ovf_refill: got %h expected %h", v, 32'h205); end
    write_reg(2'd2, 32'h3);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL flush_status: got %h expected %h", v, 32'h0); end
    read_reg(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL flush_data: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) send_key({24'h0, 8'(8'h80 + i)});
    key_with_op(32'h000000A0, 1'b1, 32'h0);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h00001003) begin errors++; $display("FAIL full_pushpop_status: got %h expected %h", v, 32'h1003); end
    for (int i = 1; i < 16; i++) begin
      pop_reg(v);
      checks++; if (v !== {8'h00, 8'(8'h80 + i), 16'h0}) begin errors++; $display("FAIL full_entry%0d: got %h expected %h", i, v, {8'h00, 8'(8'h80 + i), 16'h0}); end
    end
    pop_reg(v);
    checks++; if (v !== 32'h00A00000) begin errors++; $display("FAIL full_tail: got %h expected %h", v, 32'h00A00000); end
  endtask

  task automatic test_flush_push();
    logic [31:0] v;
    do_reset();
    send_key(32'h00000029);
    key_with_op(32'h0000002B, 1'b0, 32'h1);
    read_reg(2'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL flush_push_status: got %h expected %h", v, 32'h0); end
    send_key(32'h00000029);
    pop_reg(v);
    checks++; if (v !== (32'h00290000 | asc(8'h20))) begin errors++; $display("FAIL flush_push_after: got %h expected %h", v, 32'h00290000 | asc(8'h20)); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    do_reset();
    send_key(32'h00000012);
    write_reg(2'd2, 32'h8);
    send_key(32'h00000058);
    #2;
    rst = 1'b0;
    #1;
    bus_if.a = 2'd1;
    #1;
    checks++; if (bus_if.spo !== 32'h0) begin errors++; $display("FAIL mid_rst_status: got %h expected %h", bus_if.spo, 32'h0); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b expected 0", bus_if.irq); end
    @(negedge clk);
    rst = 1'b1;
    bus_if.a = 2'd0;
    @(negedge clk);
    send_key(32'h0000001C);
    pop_reg(v);
    checks++; if (v !== (32'h001C0000 | asc(8'h61))) begin errors++; $display("FAIL mid_rst_mods: got %h expected %h", v, 32'h001C0000 | asc(8'h61)); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_basic();
    test_modifiers();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_flush_push();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
